// File: rtl/sipo_shift_register_writer.sv
// Serialises a parallel word into a chain of 74HC595-style
// shift registers, then latches it with an rclk pulse.
module sipo_shift_register_writer #(
  parameter int WIDTH     = 16,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             done,
  output logic             ser_out,
  output logic             srclk,
  output logic             rclk,
  output logic             oe_n
);

  localparam int BW = $clog2(WIDTH) + 1;
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    LATCH
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_n;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_n;
  logic [DW-1:0]    div_cnt;
  logic [DW-1:0]    div_n;
  logic             div_end;
  logic             fin;

  function automatic logic first_bit(
    input logic [WIDTH-1:0] v
  );
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(
    input logic [WIDTH-1:0] v
  );
    if (MSB_FIRST)
      return {v[WIDTH-2:0], 1'b0};
    else
      return {1'b0, v[WIDTH-1:1]};
  endfunction

  assign ready   = (state == IDLE);
  assign div_end = (div_cnt == DIV_LAST);

  // Next-state, shadow shift and counter sequencing.
  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    bit_n    = bit_cnt;
    div_n    = div_cnt;
    fin      = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          state_n  = SETUP;
          shadow_n = data_in;
          bit_n    = '0;
          div_n    = '0;
        end
      end
      SETUP: begin
        if (div_end) begin
          state_n = HIGH;
          div_n   = '0;
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      HIGH: begin
        if (div_end) begin
          div_n = '0;
          if (bit_cnt == BIT_LAST) begin
            state_n = LATCH;
          end else begin
            state_n  = SETUP;
            shadow_n = advance(shadow);
            bit_n    = bit_cnt + 1'b1;
          end
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      LATCH: begin
        if (div_end) begin
          state_n = IDLE;
          div_n   = '0;
          fin     = 1'b1;
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and pin registers; pins follow the next state so
  // they change together with it and never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shadow  <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      ser_out <= 1'b0;
      srclk   <= 1'b0;
      rclk    <= 1'b0;
      done    <= 1'b0;
      oe_n    <= 1'b1;
    end else begin
      state   <= state_n;
      shadow  <= shadow_n;
      bit_cnt <= bit_n;
      div_cnt <= div_n;
      srclk   <= (state_n == HIGH);
      rclk    <= (state_n == LATCH);
      done    <= fin;
      if (fin)
        oe_n <= 1'b0;
      if (state_n == SETUP)
        ser_out <= first_bit(shadow_n);
    end
  end

endmodule

// File: tb/tb_sipo_shift_register_writer.sv
// Bench for sipo_shift_register_writer: two configurations
// against a time-since-accept reference model.
module tb_sipo_shift_register_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        rst [2];
  logic        ld  [2];
  logic [15:0] din [2];
  logic        rdy [2];
  logic        dn  [2];
  logic        so  [2];
  logic        sk  [2];
  logic        rk  [2];
  logic        oe  [2];

  sipo_shift_register_writer #(
    .WIDTH(16), .CLK_DIV(4), .MSB_FIRST(1'b1)
  ) u0 (
    .clk(clk), .reset(rst[0]),
    .data_in(din[0]), .load(ld[0]),
    .ready(rdy[0]), .done(dn[0]),
    .ser_out(so[0]), .srclk(sk[0]),
    .rclk(rk[0]), .oe_n(oe[0])
  );

  sipo_shift_register_writer #(
    .WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b0)
  ) u1 (
    .clk(clk), .reset(rst[1]),
    .data_in(din[1][7:0]), .load(ld[1]),
    .ready(rdy[1]), .done(dn[1]),
    .ser_out(so[1]), .srclk(sk[1]),
    .rclk(rk[1]), .oe_n(oe[1])
  );

  function automatic int pw(int g);
    return (g == 0) ? 16 : 8;
  endfunction
  function automatic int pc(int g);
    return (g == 0) ? 4 : 1;
  endfunction
  function automatic bit pm(int g);
    return (g == 0);
  endfunction
  function automatic int pend(int g);
    return 2 * pc(g) * pw(g) + pc(g) + 1;
  endfunction

  // reference model: cycles elapsed since the accept cycle
  bit          busy  [2];
  int          t     [2];
  logic [15:0] word  [2];
  bit          oem   [2];
  bit          armed [2];

  // observers
  bit          psk  [2];
  bit          prk  [2];
  bit          prdy [2];
  int          fb   [2];
  int          nrise[2];
  int          rkc  [2];
  int          rkf  [2];
  int          dnc  [2];
  int          dat  [2];
  int          t0   [2];
  logic [15:0] cap  [2];

  task automatic chk(string nm, int g,
                     logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h",
               nm, g, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(int g);
    return {26'b0, rdy[g], dn[g], so[g],
            sk[g], rk[g], oe[g]};
  endfunction

  task automatic model_edge();
    for (int g = 0; g < 2; g++) begin
      bit r;
      r = !busy[g] || t[g] == pend(g);
      if (rst[g]) begin
        busy[g]  = 1'b0;
        t[g]     = 0;
        oem[g]   = 1'b1;
        armed[g] = 1'b1;
      end else if (armed[g]) begin
        if (r && ld[g]) begin
          busy[g] = 1'b1;
          t[g]    = 1;
          word[g] = (g == 0) ? din[g]
                             : {8'h00, din[g][7:0]};
        end else if (busy[g]) begin
          if (t[g] == pend(g))
            busy[g] = 1'b0;
          else
            t[g]++;
        end
        if (busy[g] && t[g] == pend(g))
          oem[g] = 1'b0;
      end
    end
  endtask

  task automatic compare();
    for (int g = 0; g < 2; g++) begin
      int w;
      int c;
      int tt;
      bit b;
      bit er, ed, ek, erk;
      w  = pw(g);
      c  = pc(g);
      tt = t[g];
      b  = busy[g];
      if (armed[g]) begin
        er  = !b || tt == pend(g);
        ed  = b && tt == pend(g);
        ek  = b && tt >= 1 && tt <= 2*c*w &&
              ((tt - 1) % (2*c)) >= c;
        erk = b && tt > 2*c*w && tt <= 2*c*w + c;
        chk("ctl", g,
            {27'b0, rdy[g], dn[g], sk[g], rk[g], oe[g]},
            {27'b0, er, ed, ek, erk, oem[g]});
        if (b && tt >= 1 && tt <= 2*c*w) begin
          int k;
          bit eb;
          k  = (tt - 1) / (2*c);
          eb = pm(g) ? word[g][w-1-k] : word[g][k];
          chk("ser", g, {31'b0, so[g]}, {31'b0, eb});
        end
      end
    end
  endtask

  task automatic observe();
    for (int g = 0; g < 2; g++) begin
      if (armed[g]) begin
        if (prdy[g] && !rdy[g]) begin
          t0[g] = cyc - 1;
          fb[g] = 0;
        end
        if (!psk[g] && sk[g]) begin
          if (fb[g] < pw(g))
            cap[g][pm(g) ? pw(g)-1-fb[g] : fb[g]] = so[g];
          fb[g]++;
          nrise[g]++;
        end
        if (rk[g]) begin
          if (!prk[g])
            rkf[g] = cyc - t0[g];
          rkc[g]++;
        end
        if (dn[g]) begin
          dnc[g]++;
          dat[g] = cyc - t0[g];
        end
        psk[g]  = sk[g];
        prk[g]  = rk[g];
        prdy[g] = rdy[g];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    compare();
    observe();
  endtask

  task automatic wait_done(int g, int max);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!dn[g] && n < max);
    chk("done_seen", g, {31'b0, dn[g]}, 32'd1);
  endtask

  initial begin
    int sd;
    int sr;
    int sk0;
    int d1;
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1;
      ld[g]  = 1'b0;
      din[g] = 16'h0;
    end
    repeat (3) step();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    step();
    chk("rst_state", 0, pk(0), 32'b100001);
    chk("rst_state", 1, pk(1), 32'b100001);

    // single frame with loads ignored mid-frame
    sd  = dnc[0];
    sr  = nrise[0];
    sk0 = rkc[0];
    din[0] = 16'hA5C3;
    ld[0]  = 1'b1;
    step();
    for (int n = 1; n < 140; n++) begin
      ld[0]  = (n == 10 || n == 60);
      din[0] = ld[0] ? 16'hFFFF : 16'h0000;
      step();
    end
    ld[0] = 1'b0;
    chk("a5_dones", 0, dnc[0] - sd, 1);
    chk("a5_done_at", 0, dat[0], 133);
    chk("a5_rises", 0, nrise[0] - sr, 16);
    chk("a5_data", 0, cap[0], 16'hA5C3);
    chk("a5_rclk_first", 0, rkf[0], 129);
    chk("a5_rclk_len", 0, rkc[0] - sk0, 4);
    chk("a5_oe", 0, {31'b0, oe[0]}, 0);

    // back-to-back frames
    din[0] = 16'h0001;
    ld[0]  = 1'b1;
    step();
    ld[0]  = 1'b0;
    din[0] = 16'h0;
    wait_done(0, 200);
    d1 = cyc;
    chk("b2b_first", 0, cap[0], 16'h0001);
    din[0] = 16'h8000;
    ld[0]  = 1'b1;
    step();
    ld[0]  = 1'b0;
    din[0] = 16'h0;
    chk("b2b_restart", 0, {31'b0, rdy[0]}, 0);
    wait_done(0, 200);
    chk("b2b_gap", 0, cyc - d1, 133);
    chk("b2b_second", 0, cap[0], 16'h8000);
    chk("b2b_done_at", 0, dat[0], 133);

    // reset in the middle of a frame
    din[0] = 16'h5A5A;
    ld[0]  = 1'b1;
    step();
    ld[0] = 1'b0;
    repeat (49) step();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk("midrst_state", 0, pk(0), 32'b100001);
    sd  = dnc[0];
    sk0 = rkc[0];
    repeat (150) step();
    chk("midrst_no_done", 0, dnc[0] - sd, 0);
    chk("midrst_no_rclk", 0, rkc[0] - sk0, 0);
    din[0] = 16'h1234;
    ld[0]  = 1'b1;
    step();
    ld[0] = 1'b0;
    wait_done(0, 200);
    chk("post_rst_data", 0, cap[0], 16'h1234);
    chk("post_rst_done_at", 0, dat[0], 133);

    // LSB-first, divide-by-1, 8-bit chain
    sr  = nrise[1];
    sk0 = rkc[1];
    din[1] = 16'h00B2;
    ld[1]  = 1'b1;
    step();
    ld[1] = 1'b0;
    wait_done(1, 50);
    chk("b2_data", 1, {24'b0, cap[1][7:0]}, 8'hB2);
    chk("b2_done_at", 1, dat[1], 18);
    chk("b2_rises", 1, nrise[1] - sr, 8);
    chk("b2_rclk_len", 1, rkc[1] - sk0, 1);
    chk("b2_rclk_first", 1, rkf[1], 17);

    // random traffic on both configurations
    repeat (4000) begin
      for (int g = 0; g < 2; g++) begin
        rst[g] = ($urandom_range(0, 299) == 0);
        ld[g]  = ($urandom_range(0, 3) == 0);
        din[g] = 16'($urandom);
      end
      step();
    end
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b0;
      ld[g]  = 1'b0;
    end
    repeat (200) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_shift_register_writer.md
Name: sipo_shift_register_writer

Overview:
Drives a chain of external serial-in/parallel-out shift registers (74HC595-style) from a parallel data word. It is the output-side counterpart of the front-panel shift-register input path: it serialises a word onto ser_out, clocks it in with srclk, and transfers it to the output latches with rclk. Typical uses are front-panel LEDs and indicator drivers. Upstream logic hands it a word through a ready/load handshake.

Parameters:
WIDTH, 16, total bits in the external register chain (two chained 8-bit devices); must be at least 2.
CLK_DIV, 4, system clocks per srclk half-period, also the rclk pulse length; must be at least 1.
MSB_FIRST, 1, 1 shifts data_in[WIDTH-1] first; 0 shifts data_in[0] first.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
reset  in  1  synchronous, active-high reset.
data_in  in  WIDTH  parallel word to transmit; sampled only on the accept cycle.
load  in  1  request to send data_in; accepted when load=1 and ready=1.
ready  out  1  block is idle and can accept a word.
done  out  1  one-cycle pulse marking the end of a frame.
ser_out  out  1  serial data to the first device's SER pin.
srclk  out  1  shift clock to the devices' SRCLK pins.
rclk  out  1  latch clock to the devices' RCLK pins.
oe_n  out  1  active-low output enable to the devices' OE pins.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values:
  - State is IDLE; ready=1; done=0; ser_out=0; srclk=0; rclk=0; oe_n=1.
  - Shadow register, bit counter and divider counter are all 0.
- Output timing:
  - ser_out, srclk, rclk, done and oe_n are registered, so no glitches reach the pins.
  - ready = (state==IDLE), decoded combinationally from the state register.
- States:
  - IDLE:
    - ready=1, srclk=0, rclk=0.
    - On load&&ready: capture data_in into the shadow register, clear bit_cnt and div_cnt, go to SETUP.
    - load while not ready is ignored; no queuing.
  - SETUP:
    - srclk=0; ser_out = current first bit of the shadow register (MSB or LSB per MSB_FIRST).
    - Stay CLK_DIV cycles, then go to HIGH.
  - HIGH:
    - srclk=1; ser_out is held stable.
    - Stay CLK_DIV cycles.
    - At the end, if bit_cnt==WIDTH-1, go to LATCH.
    - Otherwise shift the shadow register by one toward the output end, bit_cnt+1, go to SETUP.
  - LATCH:
    - srclk=0, rclk=1 for CLK_DIV cycles; then go to IDLE.
    - On that same transition: done=1 for exactly one cycle and oe_n=0.
    - oe_n stays 0 until the next reset.
- Frame timing (accept cycle = T0):
  - SETUP of bit k starts at T1+2*CLK_DIV*k.
  - Exactly WIDTH srclk rising edges per frame.
  - LATCH occupies T(1+2*CLK_DIV*WIDTH) for CLK_DIV cycles.
  - done and ready=1 occur at T(1+2*CLK_DIV*WIDTH+CLK_DIV).
  - Default parameters: done at T133; ready=0 for T1..T132.
- Data setup: ser_out is stable for CLK_DIV cycles before every srclk rise and throughout srclk high.
- Back-to-back: load asserted in the done cycle is accepted, because ready=1 in that cycle. The next SETUP starts on the following cycle, and rclk returns to 0 before the next frame's first srclk rise.
- data_in changes after the accept cycle do not affect the frame in progress.
- Reset mid-frame:
  - Abort immediately to the reset values; no rclk pulse, no done.
  - oe_n returns to 1, so the devices show nothing until a complete frame is latched.
- Counters:
  - div_cnt is $clog2(CLK_DIV)+1 bits and counts 0..CLK_DIV-1.
  - bit_cnt is $clog2(WIDTH)+1 bits.
  - Neither counter wraps within a frame.

Test Plan:
- Reset: hold reset 3 cycles, release -> ready=1, ser_out=0, srclk=0, rclk=0, done=0, oe_n=1.
- Default parameters, load 16'hA5C3 at T0 -> 16 srclk rises. ser_out sampled at each rise reconstructs 16'hA5C3 MSB first. rclk high T129..T132. done=1 only at T133; oe_n=0 from T133.
- During the frame, pulse load with data_in=16'hFFFF at T10 and T60 -> ignored; the serial stream stays 16'hA5C3; only one done.
- Back-to-back: load 16'h0001 at T0, then 16'h8000 on the done cycle -> second frame's first SETUP on the next cycle; second frame reads 16'h8000; two done pulses 133 cycles apart.
- Reset mid-frame at T50 -> outputs return to reset values the next cycle; no rclk or done. A subsequent load of 16'h1234 transmits correctly.
- MSB_FIRST=0, CLK_DIV=1, WIDTH=8, load 8'hB2 -> bit order 0,1,0,0,1,1,0,1; srclk toggles every cycle; rclk is a 1-cycle pulse; done at T18.
